// File: rtl/uart_pkg.sv
// Shared UART byte type and data width.
package uart_pkg;
   localparam int unsigned UART_DW = 8;
   typedef logic [UART_DW-1:0] uart_byte_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned PW = AW + 1
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  uart_byte_t    wr_data,
   output uart_byte_t    rd_data,
   output logic          full,
   output logic          empty,
   output logic [PW-1:0] count
);

   uart_byte_t    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // Pointer update; flush overrides any same-cycle push or pop.
   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Storage write; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   assign rd_data = mem[rd_ptr[AW-1:0]];
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign count   = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_buffer.sv
// TX and RX byte buffering between a host and uart_core.
module uart_buffer
   import uart_pkg::*;
#(
   parameter int unsigned TX_DEPTH = 16,
   parameter int unsigned RX_DEPTH = 16,
   localparam int unsigned TXCW = $clog2(TX_DEPTH) + 1,
   localparam int unsigned RXCW = $clog2(RX_DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst_b,
   input  logic            host_tx_valid,
   input  uart_byte_t      host_tx_data,
   output logic            host_tx_ready,
   output logic            core_tx_valid,
   output uart_byte_t      core_tx_data,
   input  logic            core_tx_ready,
   input  logic            core_rx_valid,
   input  uart_byte_t      core_rx_data,
   output logic            host_rx_valid,
   output uart_byte_t      host_rx_data,
   input  logic            host_rx_ready,
   input  logic            flush_tx,
   input  logic            flush_rx,
   input  logic            clr_overflow,
   output logic [TXCW-1:0] tx_count,
   output logic [RXCW-1:0] rx_count,
   output logic            rx_overflow
);

   logic out_of_reset;
   logic tx_full, tx_empty, tx_push, tx_pop;
   logic rx_full, rx_empty, rx_push, rx_pop, rx_drop;

   // Holds host_tx_ready low until the first clock after reset release.
   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) out_of_reset <= 1'b0;
      else       out_of_reset <= 1'b1;
   end

   assign host_tx_ready = out_of_reset && !tx_full;
   assign core_tx_valid = !tx_empty;
   assign host_rx_valid = !rx_empty;

   assign tx_push = host_tx_valid && host_tx_ready;
   assign tx_pop  = core_tx_valid && core_tx_ready;
   assign rx_pop  = host_rx_valid && host_rx_ready;
   // A full RX FIFO still accepts a byte when the head leaves in the same cycle.
   assign rx_push = core_rx_valid && (!rx_full || rx_pop);
   assign rx_drop = core_rx_valid && rx_full && !rx_pop && !flush_rx;

   // Sticky overflow flag; a drop wins over a same-cycle clear.
   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b)                         rx_overflow <= 1'b0;
      else if (rx_drop)                  rx_overflow <= 1'b1;
      else if (clr_overflow || flush_rx) rx_overflow <= 1'b0;
   end

   uart_sync_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst_b   (rst_b),
      .push    (tx_push),
      .pop     (tx_pop),
      .flush   (flush_tx),
      .wr_data (host_tx_data),
      .rd_data (core_tx_data),
      .full    (tx_full),
      .empty   (tx_empty),
      .count   (tx_count)
   );

   uart_sync_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .rst_b   (rst_b),
      .push    (rx_push),
      .pop     (rx_pop),
      .flush   (flush_rx),
      .wr_data (core_rx_data),
      .rd_data (host_rx_data),
      .full    (rx_full),
      .empty   (rx_empty),
      .count   (rx_count)
   );

endmodule

// File: tb/tb_uart_buffer.sv
// Self-checking bench for uart_buffer: queue model plus directed tests.
module tb_uart_buffer;
   localparam int unsigned TXD = 16;
   localparam int unsigned RXD = 16;

   logic       clk = 1'b0;
   logic       rst_b = 1'b1;
   logic       host_tx_valid = 1'b0;
   logic [7:0] host_tx_data = '0;
   logic       host_tx_ready;
   logic       core_tx_valid;
   logic [7:0] core_tx_data;
   logic       core_tx_ready = 1'b0;
   logic       core_rx_valid = 1'b0;
   logic [7:0] core_rx_data = '0;
   logic       host_rx_valid;
   logic [7:0] host_rx_data;
   logic       host_rx_ready = 1'b0;
   logic       flush_tx = 1'b0;
   logic       flush_rx = 1'b0;
   logic       clr_overflow = 1'b0;
   logic [4:0] tx_count;
   logic [4:0] rx_count;
   logic       rx_overflow;

   always #5 clk = ~clk;

   uart_buffer #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
      .clk           (clk),
      .rst_b         (rst_b),
      .host_tx_valid (host_tx_valid),
      .host_tx_data  (host_tx_data),
      .host_tx_ready (host_tx_ready),
      .core_tx_valid (core_tx_valid),
      .core_tx_data  (core_tx_data),
      .core_tx_ready (core_tx_ready),
      .core_rx_valid (core_rx_valid),
      .core_rx_data  (core_rx_data),
      .host_rx_valid (host_rx_valid),
      .host_rx_data  (host_rx_data),
      .host_rx_ready (host_rx_ready),
      .flush_tx      (flush_tx),
      .flush_rx      (flush_rx),
      .clr_overflow  (clr_overflow),
      .tx_count      (tx_count),
      .rx_count      (rx_count),
      .rx_overflow   (rx_overflow)
   );

   int  n_tests = 0;
   int  n_fail  = 0;
   bit  done    = 1'b0;

   // Behavioural model state: byte queues plus two flags.
   logic [7:0] txq[$];
   logic [7:0] rxq[$];
   bit         m_rdy = 1'b0;
   bit         m_ovf = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      txq.delete();
      rxq.delete();
      m_rdy = 1'b0;
      m_ovf = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs presented before it.
   task automatic model_step();
      bit tx_acc, tx_out, rx_out;
      if (rst_b) begin
         model_reset();
         return;
      end
      tx_acc = m_rdy && (txq.size() < TXD) && host_tx_valid;
      tx_out = (txq.size() > 0) && core_tx_ready;
      if (flush_tx) txq.delete();
      else begin
         if (tx_out) void'(txq.pop_front());
         if (tx_acc) txq.push_back(host_tx_data);
      end
      rx_out = (rxq.size() > 0) && host_rx_ready;
      if (flush_rx) begin
         rxq.delete();
         m_ovf = 1'b0;
      end else begin
         if (clr_overflow) m_ovf = 1'b0;
         if (rx_out) void'(rxq.pop_front());
         if (core_rx_valid) begin
            if (rxq.size() < RXD) rxq.push_back(core_rx_data);
            else                  m_ovf = 1'b1;
         end
      end
      m_rdy = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      host_tx_valid = 1'b0;
      core_rx_valid = 1'b0;
      host_rx_ready = 1'b0;
      core_tx_ready = 1'b0;
      flush_tx      = 1'b0;
      flush_rx      = 1'b0;
      clr_overflow  = 1'b0;
   endtask

   // Per-cycle comparison of every output against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (!done) begin
            check("host_tx_ready", int'(host_tx_ready), int'(m_rdy && txq.size() < TXD));
            check("core_tx_valid", int'(core_tx_valid), int'(txq.size() > 0));
            if (txq.size() > 0) check("core_tx_data", int'(core_tx_data), int'(txq[0]));
            check("host_rx_valid", int'(host_rx_valid), int'(rxq.size() > 0));
            if (rxq.size() > 0) check("host_rx_data", int'(host_rx_data), int'(rxq[0]));
            check("tx_count", int'(tx_count), txq.size());
            check("rx_count", int'(rx_count), rxq.size());
            check("rx_overflow", int'(rx_overflow), int'(m_ovf));
         end
      end
   end

   initial begin
      @(negedge clk);
      #1;
      // Reset state
      tick();
      check("rst_tx_ready", int'(host_tx_ready), 0);
      check("rst_tx_valid", int'(core_tx_valid), 0);
      check("rst_rx_valid", int'(host_rx_valid), 0);
      check("rst_counts", int'({tx_count, rx_count}), 0);
      check("rst_ovf", int'(rx_overflow), 0);
      rst_b = 1'b0;
      tick();
      check("ready_after_release", int'(host_tx_ready), 1);

      // Single push latency
      host_tx_valid = 1'b1; host_tx_data = 8'hA5;
      tick();
      idle();
      check("a5_valid", int'(core_tx_valid), 1);
      check("a5_data", int'(core_tx_data), 8'hA5);
      check("a5_count", int'(tx_count), 1);
      core_tx_ready = 1'b1;
      tick();
      idle();
      check("a5_drained", int'(core_tx_valid), 0);

      // TX fill and ordered drain
      for (int i = 0; i < 16; i++) begin
         host_tx_valid = 1'b1; host_tx_data = 8'(i);
         tick();
      end
      idle();
      check("txfull_ready", int'(host_tx_ready), 0);
      check("txfull_count", int'(tx_count), 16);
      core_tx_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("tx_order", int'(core_tx_data), i);
         tick();
      end
      idle();
      check("tx_empty", int'(core_tx_valid), 0);

      // RX ordering
      for (int i = 1; i <= 3; i++) begin
         core_rx_valid = 1'b1; core_rx_data = 8'(i * 8'h11);
         tick();
      end
      idle();
      check("rx3_count", int'(rx_count), 3);
      host_rx_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         check("rx_order", int'(host_rx_data), i * 8'h11);
         tick();
      end
      idle();
      check("rx_empty", int'(host_rx_valid), 0);

      // RX overflow: drop, clear, pop-while-full accept, set-beats-clear, flush
      for (int i = 0; i < 16; i++) begin
         core_rx_valid = 1'b1; core_rx_data = 8'(8'h40 + i);
         tick();
      end
      core_rx_data = 8'h77;
      tick();
      idle();
      check("ovf_count", int'(rx_count), 16);
      check("ovf_set", int'(rx_overflow), 1);
      check("ovf_head", int'(host_rx_data), 8'h40);
      clr_overflow = 1'b1;
      tick();
      idle();
      check("ovf_clr", int'(rx_overflow), 0);
      core_rx_valid = 1'b1; core_rx_data = 8'h77; host_rx_ready = 1'b1;
      tick();
      idle();
      check("popfull_ovf", int'(rx_overflow), 0);
      check("popfull_count", int'(rx_count), 16);
      check("popfull_head", int'(host_rx_data), 8'h41);
      core_rx_valid = 1'b1; core_rx_data = 8'h88; clr_overflow = 1'b1;
      tick();
      idle();
      check("set_beats_clr", int'(rx_overflow), 1);
      flush_rx = 1'b1; core_rx_valid = 1'b1;
      tick();
      idle();
      check("flushrx_count", int'(rx_count), 0);
      check("flushrx_ovf", int'(rx_overflow), 0);

      // TX flush beats same-cycle push
      for (int i = 0; i < 5; i++) begin
         host_tx_valid = 1'b1; host_tx_data = 8'(8'h60 + i);
         tick();
      end
      check("pre_flush_count", int'(tx_count), 5);
      host_tx_data = 8'h99; flush_tx = 1'b1;
      tick();
      idle();
      check("flushtx_count", int'(tx_count), 0);
      check("flushtx_valid", int'(core_tx_valid), 0);

      // Asynchronous reset with traffic in both FIFOs
      for (int i = 0; i < 8; i++) begin
         host_tx_valid = 1'b1; host_tx_data = 8'(8'hB0 + i);
         core_rx_valid = 1'b1; core_rx_data = 8'(8'hD0 + i);
         tick();
      end
      idle();
      check("pre_rst_counts", int'({tx_count, rx_count}), (8 << 5) | 8);
      #2;
      rst_b = 1'b1;
      model_reset();
      #1;
      check("async_tx_count", int'(tx_count), 0);
      check("async_rx_count", int'(rx_count), 0);
      check("async_valids", int'({core_tx_valid, host_rx_valid}), 0);
      check("async_ready", int'(host_tx_ready), 0);
      @(negedge clk);
      #1;
      tick();
      tick();
      rst_b = 1'b0;
      tick();
      check("resume_ready", int'(host_tx_ready), 1);
      host_tx_valid = 1'b1; host_tx_data = 8'h5A;
      core_rx_valid = 1'b1; core_rx_data = 8'hC3;
      tick();
      idle();
      check("resume_tx", int'(core_tx_data), 8'h5A);
      check("resume_rx", int'(host_rx_data), 8'hC3);
      check("resume_counts", int'({tx_count, rx_count}), (1 << 5) | 1);
      tick();

      done = 1'b1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
